cache_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared cache lookup port. It accepts read/write address requests from two masters (port 0 and port 1) and grants them round-robin. It drives one request at a time into the cache with a valid/ready handshake, waits for the hit/miss response and returns it to the granted master. It also keeps saturating read, write and miss counters and recovers from a non-responding cache with a timeout.

---
 rtl/cache_arbiter.sv | 131 +++++++++++++
 tb/tb_cache_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter that sequences two requesters onto a single cache lookup port.
// It allows one outstanding request, keeps saturating read/write/miss statistics and recovers from a cache that never responds.
module cache_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid0,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic              req_we0,
    output logic              req_ready0,
    input  logic              req_valid1,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic              req_we1,
    output logic              req_ready1,
    output logic              resp_valid0,
    output logic              resp_valid1,
    output logic              resp_hit,
    output logic              resp_err,
    output logic              cache_req_valid,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_we,
    input  logic              cache_ready,
    input  logic              cache_resp_valid,
    input  logic              cache_resp_hit,
    output logic [CNT_W-1:0]  num_reads,
    output logic [CNT_W-1:0]  num_writes,
    output logic [CNT_W-1:0]  num_misses,
    output logic              busy
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             prio;
    logic             owner;
    logic [TMO_W-1:0] tmo_cnt;
    logic             grant0, grant1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req_valid0 && req_valid1) begin
            grant0 = !prio;
            grant1 = prio;
        end else begin
            grant0 = req_valid0;
            grant1 = req_valid1;
        end
    end

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign req_ready0 = (state_q == IDLE) && reset && grant0;
    assign req_ready1 = (state_q == IDLE) && reset && grant1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_ready0 || req_ready1) state_d = ISSUE;
            ISSUE:   if (cache_ready) state_d = WAIT;
            WAIT:    if (cache_resp_valid || tmo_cnt == TMO_LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cache_req_valid = (state_q == ISSUE);
    assign resp_valid0     = (state_q == RESP) && !owner;
    assign resp_valid1     = (state_q == RESP) && owner;
    assign busy            = (state_q != IDLE);

    // NOTE: all state, including the latched request and the statistics, is cleared by the
    // asynchronous reset; an in-flight transaction is simply dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            tmo_cnt    <= '0;
            cache_addr <= '0;
            cache_we   <= 1'b0;
            resp_hit   <= 1'b0;
            resp_err   <= 1'b0;
            num_reads  <= '0;
            num_writes <= '0;
            num_misses <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_ready0 || req_ready1) begin
                        owner      <= req_ready1;
                        cache_addr <= req_ready1 ? req_addr1 : req_addr0;
                        cache_we   <= req_ready1 ? req_we1 : req_we0;
                    end
                end
                ISSUE: begin
                    if (cache_ready) tmo_cnt <= '0;
                end
                WAIT: begin
                    if (cache_resp_valid) begin
                        resp_hit <= cache_resp_hit;
                        resp_err <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        resp_hit <= 1'b0;
                        resp_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RESP: begin
                    if (!cache_we && num_reads != '1) num_reads <= num_reads + CNT_W'(1);
                    if (cache_we && num_writes != '1) num_writes <= num_writes + CNT_W'(1);
                    // A timeout is reported as an error and is not counted as a miss.
                    if (!resp_hit && !resp_err && num_misses != '1)
                        num_misses <= num_misses + CNT_W'(1);
                    prio <= !owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: a negedge monitor models arbitration and statistics,
// and expected responses are queued at each handshake and matched when resp_validN fires.
module tb_cache_arbiter;

    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              req_valid0, req_valid1;
    logic [ADDR_W-1:0] req_addr0, req_addr1;
    logic              req_we0, req_we1;
    logic              req_ready0, req_ready1;
    logic              resp_valid0, resp_valid1;
    logic              resp_hit, resp_err;
    logic              cache_req_valid;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_we;
    logic              cache_ready;
    logic              cache_resp_valid;
    logic              cache_resp_hit;
    logic [CNT_W-1:0]  num_reads, num_writes, num_misses;
    logic              busy;

    cache_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid0(req_valid0), .req_addr0(req_addr0), .req_we0(req_we0), .req_ready0(req_ready0),
        .req_valid1(req_valid1), .req_addr1(req_addr1), .req_we1(req_we1), .req_ready1(req_ready1),
        .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
        .resp_hit(resp_hit), .resp_err(resp_err),
        .cache_req_valid(cache_req_valid), .cache_addr(cache_addr), .cache_we(cache_we),
        .cache_ready(cache_ready), .cache_resp_valid(cache_resp_valid), .cache_resp_hit(cache_resp_hit),
        .num_reads(num_reads), .num_writes(num_writes), .num_misses(num_misses),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic port;
        logic we;
        logic hit;
        logic err;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_idle = 1'b1;
    bit   m_prio = 1'b0;
    bit   cnt_pending = 1'b0;
    int   m_reads = 0, m_writes = 0, m_misses = 0;
    int   m_hs_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: arbitration, scoreboard and statistics, all evaluated mid-cycle.
    always @(negedge clk) begin
        bit   exp_r0, exp_r1;
        exp_t e;
        if (!reset) begin
            sb.delete();
            m_idle      = 1'b1;
            m_prio      = 1'b0;
            cnt_pending = 1'b0;
            m_reads     = 0;
            m_writes    = 0;
            m_misses    = 0;
        end else begin
            exp_r0 = m_idle && req_valid0 && (!req_valid1 || !m_prio);
            exp_r1 = m_idle && req_valid1 && (!req_valid0 || m_prio);
            check("req_ready", {30'd0, req_ready1, req_ready0}, {30'd0, exp_r1, exp_r0});
            if (cnt_pending) begin
                check("num_reads", 32'(num_reads), m_reads);
                check("num_writes", 32'(num_writes), m_writes);
                check("num_misses", 32'(num_misses), m_misses);
                cnt_pending = 1'b0;
            end
            if (resp_valid0 || resp_valid1) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", {30'd0, resp_valid1, resp_valid0}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_port", {30'd0, resp_valid1, resp_valid0}, e.port ? 32'd2 : 32'd1);
                    check("resp_hit", 32'(resp_hit), 32'(e.hit));
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    if (e.we) begin
                        if (m_writes < CMAX) m_writes++;
                    end else begin
                        if (m_reads < CMAX) m_reads++;
                    end
                    if (!e.hit && !e.err && m_misses < CMAX) m_misses++;
                    m_prio      = !e.port;
                    m_idle      = 1'b1;
                    cnt_pending = 1'b1;
                end
            end
            if (exp_r0 || exp_r1) begin
                e.port = exp_r1;
                e.we   = exp_r1 ? req_we1 : req_we0;
                e.hit  = cache_resp_valid ? cache_resp_hit : 1'b0;
                e.err  = !cache_resp_valid;
                sb.push_back(e);
                grant_log.push_back(exp_r1);
                m_idle = 1'b0;
                m_hs_cnt++;
            end
        end
    end

    task automatic set_port(input bit p, input bit v, input logic [31:0] a, input bit w);
        if (p) begin
            req_valid1 = v; req_addr1 = a; req_we1 = w;
        end else begin
            req_valid0 = v; req_addr0 = a; req_we0 = w;
        end
    endtask

    // Waits for this port's ready; on return the handshake edge has just passed.
    task automatic wait_accept(input bit p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? req_ready1 : req_ready0) && n < 200);
        if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit p, input logic [31:0] a, input bit w);
        @(posedge clk);
        #1;
        set_port(p, 1'b1, a, w);
        wait_accept(p);
        set_port(p, 1'b0, a, w);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || busy || !m_idle) && n < 500);
        if (n >= 500) check("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (m_hs_cnt < target && n < budget);
        if (n >= budget) check("hs_timeout", 32'(m_hs_cnt), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cache_req_valid"}, 32'(cache_req_valid), 32'd0);
        check({tag, "_resp_valid"}, {30'd0, resp_valid1, resp_valid0}, 32'd0);
        check({tag, "_resp_hit_err"}, {30'd0, resp_hit, resp_err}, 32'd0);
        check({tag, "_cache_addr_we"}, cache_addr ^ 32'(cache_we), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_counters"}, 32'(num_reads) | 32'(num_writes) | 32'(num_misses), 32'd0);
        check({tag, "_req_ready"}, {30'd0, req_ready1, req_ready0}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bit seen;
        int base;
        reset = 1'b0;
        req_valid0 = 1'b0; req_addr0 = '0; req_we0 = 1'b0;
        req_valid1 = 1'b0; req_addr1 = '0; req_we1 = 1'b0;
        cache_ready = 1'b1;
        cache_resp_valid = 1'b1;
        cache_resp_hit = 1'b1;

        // Reset state, with a requester already asserting valid.
        req_valid0 = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        req_valid0 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single read hit from port 0 at minimum latency.
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b1, 32'h0000_1040, 1'b0);
        @(negedge clk);
        check("t1_ready_T", 32'(req_ready0), 32'd1);
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("t1_cache_req_T1", 32'(cache_req_valid), 32'd1);
        check("t1_cache_addr", cache_addr, 32'h0000_1040);
        @(negedge clk);
        check("t1_resp_not_T2", 32'(resp_valid0), 32'd0);
        @(negedge clk);
        check("t1_resp_T3", {30'd0, resp_valid1, resp_valid0, resp_hit}, 32'b011);
        @(negedge clk);
        check("t1_num_reads", 32'(num_reads), 32'd1);
        check("t1_num_misses", 32'(num_misses), 32'd0);
        wait_idle();

        // Both ports request together from reset, all misses.
        pulse_reset();
        cache_resp_hit = 1'b0;
        grant_log.delete();
        fork
            do_req(1'b0, 32'h100, 1'b1);
            do_req(1'b1, 32'h200, 1'b0);
        join
        wait_idle();
        check("t2_order", {30'd0, grant_log[0], grant_log[1]}, 32'b01);
        check("t2_num_writes", 32'(num_writes), 32'd1);
        check("t2_num_reads", 32'(num_reads), 32'd1);
        check("t2_num_misses", 32'(num_misses), 32'd2);

        // Both valid continuously for six transactions: grants alternate.
        grant_log.delete();
        base = m_hs_cnt;
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b1, 32'h300, 1'b0);
        set_port(1'b1, 1'b1, 32'h400, 1'b1);
        wait_hs(base + 6, 100);
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b0, 32'h0, 1'b0);
        set_port(1'b1, 1'b0, 32'h0, 1'b0);
        wait_idle();
        check("t3_grants", grant_log.size() == 6 ? {grant_log[0], grant_log[1], grant_log[2],
              grant_log[3], grant_log[4], grant_log[5]} : 32'hFFFF, 32'b010101);

        // Cache stalls ISSUE for five cycles; request must stay stable.
        cache_ready = 1'b0;
        cache_resp_hit = 1'b1;
        @(posedge clk);
        #1;
        set_port(1'b1, 1'b1, 32'hCAFE_0080, 1'b1);
        wait_accept(1'b1);
        set_port(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_valid", 32'(cache_req_valid), 32'd1);
            check("t4_stall_addr", cache_addr, 32'hCAFE_0080);
        end
        check("t4_stall_we", 32'(cache_we), 32'd1);
        @(posedge clk);
        #1;
        cache_ready = 1'b1;
        wait_idle();

        // Cache never responds: error response TIMEOUT cycles after entering WAIT.
        cache_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b1, 32'h0000_5000, 1'b0);
        wait_accept(1'b0);
        set_port(1'b0, 1'b0, 32'h0, 1'b0);
        seen = 1'b0;
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            @(negedge clk);
            if (resp_valid0 || resp_valid1) seen = 1'b1;
        end
        check("t5_early_resp", 32'(seen), 32'd0);
        @(negedge clk);
        check("t5_tmo_resp", {29'd0, resp_valid0, resp_err, resp_hit}, 32'b110);
        wait_idle();
        cache_resp_valid = 1'b1;

        // 4100 read misses: statistics saturate.
        cache_resp_hit = 1'b0;
        base = m_hs_cnt;
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b1, 32'h0001_0000, 1'b0);
        wait_hs(base + 4100, 20000);
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b0, 32'h0, 1'b0);
        wait_idle();
        check("t6_reads_sat", 32'(num_reads), 32'(CMAX));
        check("t6_misses_sat", 32'(num_misses), 32'(CMAX));

        // Reset asserted during WAIT: transaction dropped, no response after release.
        cache_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        set_port(1'b0, 1'b1, 32'h0002_0000, 1'b0);
        wait_accept(1'b0);
        set_port(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t7_in_wait", {30'd0, busy, cache_req_valid}, 32'b10);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid0 = 1'b1;
        @(negedge clk);
        check_reset_outputs("t7_rst");
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        reset = 1'b1;
        cache_resp_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid0 || resp_valid1) seen = 1'b1;
        end
        check("t7_no_resp", 32'(seen), 32'd0);
        check("t7_counters", 32'(num_reads) | 32'(num_misses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
